// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: frame width, default baud divisor and serialiser states.
// The matching UART receiver imports the same package.
package uart_tx_fifo_pkg;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock synchronous FIFO with first-word-fall-through read data.
// Occupancy is tracked explicitly; full/empty are decoded from it.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_level == (AW+1)'(DEPTH));
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];

  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: csr pushes bytes into a FIFO, the serialiser
// drains it back-to-back onto txd with a configurable number of stop bits.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic               busy,
  output logic               overflow,
  input  logic               clr_ovrflw,
  output logic               txd
);

  localparam int unsigned BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [BW-1:0] r_baud_cnt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_txd;
  logic        w_txd_nxt;
  logic        r_overflow;
  logic        w_pop;
  logic        w_baud_done;
  logic [7:0]  w_rd_data;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign busy        = (r_state != ST_IDLE);
  assign txd         = r_txd;
  assign overflow    = r_overflow;
  assign w_baud_done = (r_baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (wr_en && full) begin
      r_overflow <= 1'b1;
    end else if (clr_ovrflw) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // bit_cnt doubles as the stop-bit counter so baud_cnt stays one bit period wide.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_txd_nxt = 1'b1;
        if (!empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rd_data;
          w_txd_nxt   = 1'b0;
          w_baud_nxt  = '0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_txd_nxt   = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_state_nxt = ST_DATA;
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_nxt   = '0;
            w_txd_nxt   = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt   = r_bit_cnt + 1'b1;
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit_cnt == STOP_LAST) begin
            w_bit_nxt = '0;
            if (!empty) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_rd_data;
              w_txd_nxt   = 1'b0;
              w_state_nxt = ST_START;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: cycle-exact single frame table, then
// back-to-back, fill/overflow, push-on-pop, mid-frame reset and 2-stop-bit cases.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr;
  logic       full, empty, busy, overflow, txd;
  logic [4:0] level;

  logic       wr_en2;
  logic [7:0] wr_data2;
  logic       clr2;
  logic       full2, empty2, busy2, overflow2, txd2;
  logic [4:0] level2;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .busy(busy),
    .overflow(overflow), .clr_ovrflw(clr), .txd(txd)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(434), .FIFO_AW(4), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .level(level2), .busy(busy2),
    .overflow(overflow2), .clr_ovrflw(clr2), .txd(txd2)
  );

  typedef struct {
    logic       wr_en;
    logic [7:0] d;
    logic       txd;
    logic       busy;
    logic [4:0] level;
  } vec_t;

  vec_t vt[60];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  function automatic logic [7:0] dpat(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  // Mid-bit sampling receiver; returns the cycle at which the start bit was first seen.
  task automatic rx_byte(output logic [7:0] b, output int fall);
    logic [7:0] t;
    int n;
    n = 0;
    t = '0;
    while (txd !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    check("rx_start_found", txd, 0);
    fall = cyc;
    tick(); tick();
    check("rx_start_mid", txd, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick();
      t[i] = txd;
    end
    repeat (4) tick();
    check("rx_stop_bit", txd, 1);
    b = t;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int f1, f2, p, lows, highs;

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr = 1'b0;
    wr_en2 = 1'b0; wr_data2 = '0; clr2 = 1'b0;
    tick(); tick();
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_txd2", txd2, 1);
    rst = 1'b0;

    // Single byte 0xA5 pushed at edge 10
    for (int c = 0; c < 60; c++) begin
      vt[c].wr_en = (c == 10);
      vt[c].d     = 8'hA5;
      if (c < 11) begin
        vt[c].txd = 1'b1; vt[c].busy = 1'b0; vt[c].level = (c == 10) ? 5'd1 : 5'd0;
      end else if (c <= 50) begin
        vt[c].txd = fbit(8'hA5, (c - 11) / CPB); vt[c].busy = 1'b1; vt[c].level = 5'd0;
      end else begin
        vt[c].txd = 1'b1; vt[c].busy = 1'b0; vt[c].level = 5'd0;
      end
    end
    for (int c = 0; c < 60; c++) begin
      wr_en   = vt[c].wr_en;
      wr_data = vt[c].d;
      tick();
      wr_en = 1'b0;
      check("t1_txd", txd, vt[c].txd);
      check("t1_busy", busy, vt[c].busy);
      check("t1_level", level, vt[c].level);
    end

    // Back-to-back frames
    wr_en = 1'b1; wr_data = 8'h55; tick();
    wr_data = 8'h0F; tick();
    wr_en = 1'b0;
    rx_byte(b, f1);
    check("t2_byte0", b, 8'h55);
    rx_byte(b, f2);
    check("t2_byte1", b, 8'h0F);
    check("t2_gap", f2 - f1, 10 * CPB);
    repeat (10) tick();
    check("t2_idle", busy, 0);

    // Fill and overflow while an all-ones frame is on the line
    push(8'hFF);
    for (int i = 0; i < 16; i++) push(dpat(i));
    check("t3_level16", level, 16);
    check("t3_full", full, 1);
    check("t3_ovf_clear", overflow, 0);
    push(8'hEE);
    check("t3_ovf_set", overflow, 1);
    check("t3_level_drop", level, 16);
    wr_en = 1'b1; clr = 1'b1; wr_data = 8'h77; tick();
    wr_en = 1'b0; clr = 1'b0;
    check("t3_set_wins", overflow, 1);
    check("t3_level_drop2", level, 16);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t3_clr", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      rx_byte(b, f1);
      check("t3_order", b, dpat(i));
    end
    tick();
    check("t3_busy_last", busy, 1);
    tick();
    check("t3_busy_end", busy, 0);
    check("t3_empty_end", empty, 1);
    check("t3_level_end", level, 0);

    // Push on the pop edge: full FIFO, then level 5
    repeat (5) tick();
    push(8'hFF);
    p = cyc;
    for (int i = 0; i < 16; i++) push(dpat(i + 3));
    check("t4_full", full, 1);
    while (cyc < p + 40) tick();
    push(8'h99);
    check("t4_ovf", overflow, 1);
    check("t4_level15", level, 15);
    check("t4_txd_start", txd, 0);
    while (cyc < p + 480) tick();
    check("t4_level5_pre", level, 5);
    push(8'h42);
    check("t4_level5_post", level, 5);

    // Reset during data bit 3 of the frame popped at edge p+481
    while (cyc < p + 481 + 16) tick();
    check("t5_busy_pre", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_txd", txd, 1);
    check("t5_busy", busy, 0);
    check("t5_empty", empty, 1);
    check("t5_level", level, 0);
    check("t5_overflow", overflow, 0);
    lows = 0;
    repeat (100) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t5_quiet", lows, 0);

    // Two stop bits at 434 clocks per bit, byte 0x00
    wr_en2 = 1'b1; wr_data2 = 8'h00; tick(); wr_en2 = 1'b0;
    check("t6_level2", level2, 1);
    tick();
    check("t6_fall", txd2, 0);
    check("t6_busy", busy2, 1);
    lows = 0;
    while (txd2 === 1'b0 && lows < 5000) begin
      lows++;
      tick();
    end
    check("t6_low_cycles", lows, 9 * 434);
    highs = 0;
    while (busy2 === 1'b1 && txd2 === 1'b1 && highs < 2000) begin
      highs++;
      tick();
    end
    check("t6_stop_cycles", highs, 2 * 434);
    check("t6_idle_busy", busy2, 0);
    check("t6_idle_txd", txd2, 1);
    check("t6_empty", empty2, 1);
    check("t6_full", full2, 0);
    check("t6_ovf", overflow2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
